// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: two requester handshakes, the RAM side and status.
// The slave modport is the arbiter; the master modport is the requesters plus the RAM.
interface mem_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          REQ0, REQ1;
  logic          WE0,  WE1;
  logic [AW-1:0] A0,   A1;
  logic [DW-1:0] WD0,  WD1;
  logic          ACK0, ACK1;
  logic [DW-1:0] RD0,  RD1;
  logic [AW-1:0] MA;
  logic [DW-1:0] MWD;
  logic          MEN;
  logic          MWE;
  logic [DW-1:0] MRD;
  logic          BUSY;
  logic          LAST;

  modport slave (
    input  REQ0, REQ1, WE0, WE1, A0, A1, WD0, WD1, MRD,
    output ACK0, ACK1, RD0, RD1, MA, MWD, MEN, MWE, BUSY, LAST
  );

  modport master (
    output REQ0, REQ1, WE0, WE1, A0, A1, WD0, WD1, MRD,
    input  ACK0, ACK1, RD0, RD1, MA, MWD, MEN, MWE, BUSY, LAST
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port RAM between two requesters.
// Fixed four-cycle transaction: IDLE (grant) -> ISSUE (RAM access) -> RESP (capture) -> DONE (ACK).
module mem_arbiter #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          CK,
  input  logic          RST,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP, DONE} state_t;

  state_t                 state_q, state_d;
  logic                   sel_q,   sel_d;
  logic                   we_q,    we_d;
  logic                   last_q,  last_d;
  logic                   men_q,   men_d;
  logic                   mwe_q,   mwe_d;
  logic [AW-1:0]          ma_q,    ma_d;
  logic [DW-1:0]          mwd_q,   mwd_d;
  logic [1:0]             ack_q,   ack_d;
  logic [1:0][DW-1:0]     rd_q,    rd_d;

  logic [1:0]             req;
  logic [1:0]             we_in;
  logic [1:0][AW-1:0]     a_in;
  logic [1:0][DW-1:0]     wd_in;
  logic                   gnt;

  assign req   = {bus.REQ1, bus.REQ0};
  assign we_in = {bus.WE1,  bus.WE0};
  assign a_in  = {bus.A1,   bus.A0};
  assign wd_in = {bus.WD1,  bus.WD0};

  // On a tie the port that did not win last time gets the RAM.
  assign gnt = (req[0] & req[1]) ? ~last_q : req[1];

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    we_d    = we_q;
    last_d  = last_q;
    ma_d    = ma_q;
    mwd_d   = mwd_q;
    rd_d    = rd_q;
    men_d   = 1'b0;
    mwe_d   = 1'b0;
    ack_d   = '0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          sel_d   = gnt;
          we_d    = we_in[gnt];
          last_d  = gnt;
          ma_d    = a_in[gnt];
          mwd_d   = wd_in[gnt];
          men_d   = 1'b1;
          mwe_d   = we_in[gnt];
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = RESP;
      RESP: begin
        // RAM data from the ISSUE access is on MRD now.
        ack_d[sel_q] = 1'b1;
        if (!we_q) rd_d[sel_q] = bus.MRD;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      we_q    <= 1'b0;
      last_q  <= 1'b1;
      men_q   <= 1'b0;
      mwe_q   <= 1'b0;
      ma_q    <= '0;
      mwd_q   <= '0;
      ack_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      last_q  <= last_d;
      men_q   <= men_d;
      mwe_q   <= mwe_d;
      ma_q    <= ma_d;
      mwd_q   <= mwd_d;
      ack_q   <= ack_d;
      rd_q    <= rd_d;
    end
  end

  assign bus.ACK0 = ack_q[0];
  assign bus.ACK1 = ack_q[1];
  assign bus.RD0  = rd_q[0];
  assign bus.RD1  = rd_q[1];
  assign bus.MA   = ma_q;
  assign bus.MWD  = mwd_q;
  assign bus.MEN  = men_q;
  assign bus.MWE  = mwe_q;
  assign bus.LAST = last_q;
  assign bus.BUSY = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural synchronous RAM on the memory side.
module tb_mem_arbiter;

  logic CK  = 1'b0;
  logic RST = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  mem_arbiter_if #(.AW(16), .DW(16)) bus ();

  mem_arbiter #(.AW(16), .DW(16)) dut (
    .CK  (CK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CK = ~CK;

  // Synchronous RAM: access sampled on the edge that closes the MEN cycle.
  logic [15:0] mem [0:255];
  logic [15:0] mrd;
  assign bus.MRD = mrd;
  always @(posedge CK) begin
    if (bus.MEN) begin
      if (bus.MWE) mem[bus.MA[7:0]] <= bus.MWD;
      else         mrd <= mem[bus.MA[7:0]];
    end
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ack_of(input int p);
    return (p == 0) ? {15'd0, bus.ACK0} : {15'd0, bus.ACK1};
  endfunction

  function automatic logic [15:0] rd_of(input int p);
    return (p == 0) ? bus.RD0 : bus.RD1;
  endfunction

  task automatic drive(input int p, input logic req, input logic we,
                       input logic [15:0] a, input logic [15:0] wd);
    if (p == 0) begin
      bus.REQ0 = req; bus.WE0 = we; bus.A0 = a; bus.WD0 = wd;
    end else begin
      bus.REQ1 = req; bus.WE1 = we; bus.A1 = a; bus.WD1 = wd;
    end
  endtask

  // One uncontended transaction, called right after a falling edge with the DUT idle.
  task automatic txn(input int p, input logic we, input logic [15:0] a, input logic [15:0] wd,
                     input logic [15:0] rd_exp, input logic [15:0] rd_oth);
    drive(p, 1'b1, we, a, wd);
    @(negedge CK);
    chk("iss_men",  {15'd0, bus.MEN},  16'd1);
    chk("iss_mwe",  {15'd0, bus.MWE},  {15'd0, we});
    chk("iss_ma",   bus.MA, a);
    if (we) chk("iss_mwd", bus.MWD, wd);
    chk("iss_last", {15'd0, bus.LAST}, p[15:0]);
    chk("iss_busy", {15'd0, bus.BUSY}, 16'd1);
    @(negedge CK);
    chk("resp_men", {15'd0, bus.MEN}, 16'd0);
    chk("resp_mwe", {15'd0, bus.MWE}, 16'd0);
    chk("resp_ack", ack_of(p), 16'd0);
    @(negedge CK);
    chk("done_ack",   ack_of(p),     16'd1);
    chk("done_ack_o", ack_of(1 - p), 16'd0);
    chk("done_rd",    rd_of(p),      rd_exp);
    chk("done_rd_o",  rd_of(1 - p),  rd_oth);
    drive(p, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge CK);
    chk("idle_ack",  ack_of(p), 16'd0);
    chk("idle_busy", {15'd0, bus.BUSY}, 16'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h10] = 16'h1234;
    mem[8'h30] = 16'hAAAA;
    mem[8'h40] = 16'h5555;
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1, 1'b0, 1'b0, 16'h0, 16'h0);

    // Reset values
    @(negedge CK);
    chk("rst_busy", {15'd0, bus.BUSY}, 16'd0);
    chk("rst_last", {15'd0, bus.LAST}, 16'd1);
    chk("rst_men",  {15'd0, bus.MEN},  16'd0);
    chk("rst_mwe",  {15'd0, bus.MWE},  16'd0);
    chk("rst_ack",  {14'd0, bus.ACK1, bus.ACK0}, 16'd0);
    chk("rst_rd0",  bus.RD0, 16'h0);
    chk("rst_rd1",  bus.RD1, 16'h0);
    chk("rst_ma",   bus.MA,  16'h0);
    chk("rst_mwd",  bus.MWD, 16'h0);
    RST = 1'b0;
    @(negedge CK);

    // Single read, write, read-back
    txn(0, 1'b0, 16'h0010, 16'h0000, 16'h1234, 16'h0000);
    txn(1, 1'b1, 16'h0020, 16'hBEEF, 16'h0000, 16'h1234);
    txn(0, 1'b0, 16'h0020, 16'h0000, 16'hBEEF, 16'h0000);

    // Address change after the grant is ignored
    drive(0, 1'b1, 1'b0, 16'h0030, 16'h0);
    @(negedge CK);
    chk("chg_ma", bus.MA, 16'h0030);
    bus.A0 = 16'h0040;
    @(negedge CK);
    chk("chg_ma_hold", bus.MA, 16'h0030);
    @(negedge CK);
    chk("chg_ack", ack_of(0), 16'd1);
    chk("chg_rd",  bus.RD0, 16'hAAAA);
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge CK);

    // Reset in the ISSUE cycle of a write
    drive(1, 1'b1, 1'b1, 16'h0060, 16'hCAFE);
    @(negedge CK);
    chk("wr_iss_mwe", {15'd0, bus.MWE}, 16'd1);
    #2 RST = 1'b1;
    #1;
    chk("arst_mwe",  {15'd0, bus.MWE},  16'd0);
    chk("arst_men",  {15'd0, bus.MEN},  16'd0);
    chk("arst_busy", {15'd0, bus.BUSY}, 16'd0);
    chk("arst_last", {15'd0, bus.LAST}, 16'd1);
    chk("arst_rd0",  bus.RD0, 16'h0);
    drive(1, 1'b0, 1'b0, 16'h0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CK);
      chk("arst_noack", {14'd0, bus.ACK1, bus.ACK0}, 16'd0);
    end
    RST = 1'b0;
    @(negedge CK);
    chk("post_rst_busy", {15'd0, bus.BUSY}, 16'd0);
    txn(0, 1'b0, 16'h0060, 16'h0000, 16'h0000, 16'h0000);

    // Contention from reset: grants alternate 0,1,0,1 with no idle gaps beyond IDLE
    RST = 1'b1;
    drive(0, 1'b1, 1'b0, 16'h0010, 16'h0);
    drive(1, 1'b1, 1'b0, 16'h0020, 16'h0);
    @(negedge CK);
    RST = 1'b0;
    for (int i = 0; i < 4; i++) begin
      int p;
      p = i % 2;
      @(negedge CK);
      chk("cont_last", {15'd0, bus.LAST}, p[15:0]);
      chk("cont_ma",   bus.MA, (p == 0) ? 16'h0010 : 16'h0020);
      @(negedge CK);
      @(negedge CK);
      chk("cont_ack",   ack_of(p),     16'd1);
      chk("cont_ack_o", ack_of(1 - p), 16'd0);
      chk("cont_rd",    rd_of(p), (p == 0) ? 16'h1234 : 16'hBEEF);
      if (i == 3) begin
        drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
        drive(1, 1'b0, 1'b0, 16'h0, 16'h0);
      end
      @(negedge CK);
      chk("cont_idle", {15'd0, bus.BUSY}, 16'd0);
    end
    @(negedge CK);
    chk("final_idle", {15'd0, bus.BUSY}, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
